// File: rtl/sif_wbus_bridge.sv
// xbus-slave to wbus-master bridge: posted writes queue in a FIFO and drain onto wbus
// through a valid/ready output register; shadow registers and a status word serve xbus reads.
module sif_wbus_bridge #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  parameter int SHADOW_N = 16,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] xa_addr,
  input  logic [DATA_W-1:0] xa_data_wr,
  input  logic              xa_wr_s,
  input  logic              xa_rd_s,
  output logic [DATA_W-1:0] xa_data_rd,
  output logic              xa_busy,
  output logic [ADDR_W-1:0] wa_addr,
  output logic [DATA_W-1:0] wa_data_wr,
  output logic              wa_wr_s,
  input  logic              wa_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SH_W = $clog2(SHADOW_N);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] SHADOW_LIM = ADDR_W'(SHADOW_N);

  typedef enum logic {ST_IDLE, ST_VALID} state_t;

  state_t state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic [6:0] drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0] xa_data_rd_q, xa_data_rd_d;
  logic xa_busy_q, xa_busy_d;
  logic [ADDR_W-1:0] wa_addr_q, wa_addr_d;
  logic [DATA_W-1:0] wa_data_q, wa_data_d;
  logic [DATA_W-1:0] shadow_q [SHADOW_N];
  logic [DATA_W-1:0] shadow_d [SHADOW_N];
  logic [ADDR_W+DATA_W-1:0] fifo_mem_q [DEPTH];

  logic is_status, in_shadow, fifo_empty, fifo_full;
  logic push, pop, drop, clr;
  logic [15:0] status_word;
  logic [SH_W-1:0] sh_idx;

  always_comb begin
    is_status   = (xa_addr == STATUS_ADDR);
    in_shadow   = (xa_addr < SHADOW_LIM);
    sh_idx      = xa_addr[SH_W-1:0];
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == FULL_CNT);
    // The output register can take the head whenever it is empty or handing off this edge.
    pop         = !fifo_empty && ((state_q == ST_IDLE) || wa_ready);
    push        = xa_wr_s && !is_status && (!fifo_full || pop);
    drop        = xa_wr_s && !is_status && fifo_full && !pop;
    clr         = xa_wr_s && is_status && xa_data_wr[0];
    status_word = {ovf_q, drop_cnt_q, 8'(count_q)};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    xa_busy_d = (count_d == FULL_CNT);
  end

  // Status clear takes priority over a same-edge overflow.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 7'h7F) drop_cnt_d = drop_cnt_q + 7'd1;
    end
  end

  always_comb begin
    xa_data_rd_d = xa_data_rd_q;
    if (xa_rd_s) begin
      if (in_shadow)      xa_data_rd_d = shadow_q[sh_idx];
      else if (is_status) xa_data_rd_d = DATA_W'(status_word);
      else                xa_data_rd_d = '0;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (xa_wr_s && in_shadow) shadow_d[sh_idx] = xa_data_wr;
  end

  always_comb begin
    state_d   = state_q;
    wa_addr_d = wa_addr_q;
    wa_data_d = wa_data_q;
    if (pop) begin
      {wa_addr_d, wa_data_d} = fifo_mem_q[rd_ptr_q];
      state_d = ST_VALID;
    end else if ((state_q == ST_VALID) && wa_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {xa_addr, xa_data_wr};
  end

  for (genvar gi = 0; gi < SHADOW_N; gi++) begin : g_shadow
    always_ff @(posedge clk or posedge rst) begin
      if (rst) shadow_q[gi] <= '0;
      else     shadow_q[gi] <= shadow_d[gi];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      drop_cnt_q   <= '0;
      xa_data_rd_q <= '0;
      xa_busy_q    <= 1'b0;
      wa_addr_q    <= '0;
      wa_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      drop_cnt_q   <= drop_cnt_d;
      xa_data_rd_q <= xa_data_rd_d;
      xa_busy_q    <= xa_busy_d;
      wa_addr_q    <= wa_addr_d;
      wa_data_q    <= wa_data_d;
    end
  end

  assign xa_data_rd = xa_data_rd_q;
  assign xa_busy    = xa_busy_q;
  assign wa_addr    = wa_addr_q;
  assign wa_data_wr = wa_data_q;
  assign wa_wr_s    = (state_q == ST_VALID);

endmodule

// File: tb/tb_sif_wbus_bridge.sv
// Bench for sif_wbus_bridge: directed scenarios plus randomized traffic against a
// transaction-level model (queue of accepted beats, shadow array, status fields).
module tb_sif_wbus_bridge;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int SHN = 16;
  localparam logic [15:0] ST_ADDR = 16'hFFFF;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] xa_addr;
  logic [DW-1:0] xa_data_wr;
  logic xa_wr_s, xa_rd_s;
  logic [DW-1:0] xa_data_rd;
  logic xa_busy;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wa_data_wr;
  logic wa_wr_s;
  logic wa_ready;

  always #5 clk = ~clk;

  sif_wbus_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .SHADOW_N(SHN), .STATUS_ADDR(ST_ADDR)
  ) dut (
    .clk(clk), .rst(rst),
    .xa_addr(xa_addr), .xa_data_wr(xa_data_wr), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_data_rd(xa_data_rd), .xa_busy(xa_busy),
    .wa_addr(wa_addr), .wa_data_wr(wa_data_wr), .wa_wr_s(wa_wr_s), .wa_ready(wa_ready)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: every accepted beat not yet handshaken, in acceptance order.
  // When 'held' is set, pend[0] is the beat presented on wbus.
  typedef struct packed { logic [15:0] a; logic [15:0] d; } beat_t;
  beat_t pend[$];
  bit held;
  logic [15:0] m_sh [SHN];
  bit m_ovf;
  int m_drop;
  logic [15:0] m_rd;

  function automatic void model_reset();
    pend.delete();
    held = 0;
    foreach (m_sh[i]) m_sh[i] = '0;
    m_ovf = 0;
    m_drop = 0;
    m_rd = '0;
  endfunction

  function automatic int m_count();
    return pend.size() - (held ? 1 : 0);
  endfunction

  function automatic logic [15:0] m_status();
    return {m_ovf, 7'(m_drop), 8'(m_count())};
  endfunction

  function automatic void model_step();
    int cnt;
    bit hs, pop, accept;
    cnt = m_count();
    hs = held && wa_ready;
    pop = (cnt > 0) && (!held || hs);
    accept = 0;
    if (xa_rd_s) begin
      if (xa_addr < SHN) m_rd = m_sh[xa_addr[3:0]];
      else if (xa_addr == ST_ADDR) m_rd = {m_ovf, 7'(m_drop), 8'(cnt)};
      else m_rd = '0;
    end
    if (xa_wr_s) begin
      if (xa_addr == ST_ADDR) begin
        if (xa_data_wr[0]) begin m_ovf = 0; m_drop = 0; end
      end else if (cnt < DEPTH || pop) begin
        accept = 1;
      end else begin
        m_ovf = 1;
        if (m_drop < 127) m_drop++;
      end
      if (xa_addr < SHN) m_sh[xa_addr[3:0]] = xa_data_wr;
    end
    if (hs) void'(pend.pop_front());
    if (pop) held = 1;
    else if (hs) held = 0;
    if (accept) pend.push_back({xa_addr, xa_data_wr});
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic write_cyc(input logic [15:0] a, input logic [15:0] d);
    xa_addr = a; xa_data_wr = d; xa_wr_s = 1'b1; xa_rd_s = 1'b0;
    cycle();
    xa_wr_s = 1'b0;
  endtask

  task automatic read_cyc(input logic [15:0] a);
    xa_addr = a; xa_rd_s = 1'b1; xa_wr_s = 1'b0;
    cycle();
    xa_rd_s = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; xa_addr = '0; xa_data_wr = '0; xa_wr_s = 1'b0; xa_rd_s = 1'b0; wa_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (xa_data_rd !== 16'h0) begin n_fail++; $display("FAIL rst_xa_data_rd: got %h want 0000", xa_data_rd); end
    n_checks++; if (xa_busy !== 1'b0) begin n_fail++; $display("FAIL rst_xa_busy: got %b want 0", xa_busy); end
    n_checks++; if (wa_addr !== 16'h0) begin n_fail++; $display("FAIL rst_wa_addr: got %h want 0000", wa_addr); end
    n_checks++; if (wa_data_wr !== 16'h0) begin n_fail++; $display("FAIL rst_wa_data_wr: got %h want 0000", wa_data_wr); end
    n_checks++; if (wa_wr_s !== 1'b0) begin n_fail++; $display("FAIL rst_wa_wr_s: got %b want 0", wa_wr_s); end
    rst = 1'b0;
    cycle();
    read_cyc(ST_ADDR);
    n_checks++; if (xa_data_rd !== 16'h0000) begin n_fail++; $display("FAIL rst_status: got %h want 0000", xa_data_rd); end
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    wa_ready = 1'b1;
    write_cyc(16'h0003, 16'hBEEF);
    n_checks++; if (wa_wr_s !== 1'b0) begin n_fail++; $display("FAIL single_lat_early: got %b want 0", wa_wr_s); end
    cycle();
    n_checks++; if (wa_wr_s !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", wa_wr_s); end
    n_checks++; if (wa_addr !== 16'h0003) begin n_fail++; $display("FAIL single_addr: got %h want 0003", wa_addr); end
    n_checks++; if (wa_data_wr !== 16'hBEEF) begin n_fail++; $display("FAIL single_data: got %h want BEEF", wa_data_wr); end
    $display("wbus beat addr=%h data=%h", wa_addr, wa_data_wr);
    cycle();
    n_checks++; if (wa_wr_s !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b want 0", wa_wr_s); end
    read_cyc(16'h0003);
    n_checks++; if (xa_data_rd !== 16'hBEEF) begin n_fail++; $display("FAIL single_readback: got %h want BEEF", xa_data_rd); end
  endtask

  task automatic test_overflow();
    wa_ready = 1'b0;
    for (int i = 0; i < 10; i++) write_cyc(16'h0100 + 16'(i), 16'(i));
    n_checks++; if (xa_busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy: got %b want 1", xa_busy); end
    n_checks++; if (wa_wr_s !== 1'b1 || wa_data_wr !== 16'h0000) begin
      n_fail++; $display("FAIL ovf_held: got valid=%b data=%h want valid=1 data=0000", wa_wr_s, wa_data_wr); end
    read_cyc(ST_ADDR);
    n_checks++; if (xa_data_rd !== 16'h8108) begin n_fail++; $display("FAIL ovf_status: got %h want 8108", xa_data_rd); end
  endtask

  task automatic test_drain();
    int got, first_c, last_c;
    got = 0; first_c = -1; last_c = -1;
    wa_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (wa_wr_s) begin
        n_checks++; if (wa_data_wr !== 16'(got) || wa_addr !== 16'h0100 + 16'(got)) begin
          n_fail++; $display("FAIL drain_beat%0d: got %h/%h want %h/%h", got, wa_addr, wa_data_wr, 16'h0100 + 16'(got), 16'(got)); end
        $display("wbus beat addr=%h data=%h", wa_addr, wa_data_wr);
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      cycle();
    end
    n_checks++; if (got !== 9) begin n_fail++; $display("FAIL drain_count: got %0d want 9", got); end
    n_checks++; if (last_c - first_c + 1 !== 9) begin n_fail++; $display("FAIL drain_b2b: got span %0d want 9", last_c - first_c + 1); end
    read_cyc(ST_ADDR);
    n_checks++; if (xa_data_rd !== 16'h8100) begin n_fail++; $display("FAIL drain_status: got %h want 8100", xa_data_rd); end
    write_cyc(ST_ADDR, 16'h0001);
    read_cyc(ST_ADDR);
    n_checks++; if (xa_data_rd !== 16'h0000) begin n_fail++; $display("FAIL w1c_status: got %h want 0000", xa_data_rd); end
  endtask

  task automatic test_toggle_random();
    bit stall;
    logic [15:0] pa, pd, ra;
    for (int i = 0; i < 80; i++) begin
      wa_ready = (i % 2 == 0);
      xa_addr = 16'($urandom_range(0, 31));
      xa_data_wr = 16'($urandom);
      xa_wr_s = 1'b1;
      stall = wa_wr_s && !wa_ready;
      pa = wa_addr; pd = wa_data_wr;
      cycle();
      n_checks++; if (wa_wr_s !== held) begin n_fail++; $display("FAIL tog_valid c%0d: got %b want %b", i, wa_wr_s, held); end
      if (held) begin
        n_checks++; if ({wa_addr, wa_data_wr} !== pend[0]) begin
          n_fail++; $display("FAIL tog_beat c%0d: got %h/%h want %h/%h", i, wa_addr, wa_data_wr, pend[0].a, pend[0].d); end
      end
      if (stall) begin
        n_checks++; if (wa_addr !== pa || wa_data_wr !== pd) begin
          n_fail++; $display("FAIL tog_stable c%0d: got %h/%h want %h/%h", i, wa_addr, wa_data_wr, pa, pd); end
      end
      n_checks++; if (xa_busy !== (m_count() == DEPTH)) begin
        n_fail++; $display("FAIL tog_busy c%0d: got %b want %b", i, xa_busy, m_count() == DEPTH); end
    end
    xa_wr_s = 1'b0;
    read_cyc(ST_ADDR);
    n_checks++; if (xa_data_rd !== m_rd) begin n_fail++; $display("FAIL tog_status: got %h want %h", xa_data_rd, m_rd); end
    wa_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (held) begin
        n_checks++; if ({wa_addr, wa_data_wr} !== pend[0]) begin
          n_fail++; $display("FAIL tog_drain c%0d: got %h/%h want %h/%h", i, wa_addr, wa_data_wr, pend[0].a, pend[0].d); end
      end
    end
    n_checks++; if (wa_wr_s !== 1'b0 || pend.size() != 0) begin
      n_fail++; $display("FAIL tog_empty: got valid=%b want 0 (model left %0d)", wa_wr_s, pend.size()); end
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom_range(0, SHN - 1));
      read_cyc(ra);
      n_checks++; if (xa_data_rd !== m_rd) begin n_fail++; $display("FAIL tog_shadow[%0d]: got %h want %h", ra, xa_data_rd, m_rd); end
    end
    write_cyc(ST_ADDR, 16'h0001);
  endtask

  task automatic test_reset_mid();
    wa_ready = 1'b1;
    write_cyc(16'h0002, 16'h1234);
    write_cyc(16'h0007, 16'h5678);
    repeat (4) cycle();
    wa_ready = 1'b0;
    for (int i = 0; i < 5; i++) write_cyc(16'h0200 + 16'(i), 16'hA000 + 16'(i));
    n_checks++; if (wa_wr_s !== 1'b1 || m_count() != 4) begin
      n_fail++; $display("FAIL rmid_pre: got valid=%b want 1 (model count %0d want 4)", wa_wr_s, m_count()); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (wa_wr_s !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got %b want 0", wa_wr_s); end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wa_ready = 1'b1;
    cycle();
    n_checks++; if (wa_wr_s !== 1'b0) begin n_fail++; $display("FAIL rmid_lost: got %b want 0", wa_wr_s); end
    read_cyc(ST_ADDR);
    n_checks++; if (xa_data_rd !== 16'h0000) begin n_fail++; $display("FAIL rmid_status: got %h want 0000", xa_data_rd); end
    read_cyc(16'h0002);
    n_checks++; if (xa_data_rd !== 16'h0000) begin n_fail++; $display("FAIL rmid_shadow2: got %h want 0000", xa_data_rd); end
    read_cyc(16'h0007);
    n_checks++; if (xa_data_rd !== 16'h0000) begin n_fail++; $display("FAIL rmid_shadow7: got %h want 0000", xa_data_rd); end
  endtask

  task automatic test_saturation();
    wa_ready = 1'b0;
    for (int i = 0; i < 9; i++) write_cyc(16'h0020, 16'h0100 + 16'(i));
    for (int i = 0; i < 140; i++) write_cyc(16'h0020, 16'($urandom));
    read_cyc(ST_ADDR);
    n_checks++; if (xa_data_rd !== 16'hFF08) begin n_fail++; $display("FAIL sat_status: got %h want FF08", xa_data_rd); end
    read_cyc(16'h0020);
    n_checks++; if (xa_data_rd !== 16'h0000) begin n_fail++; $display("FAIL sat_unmapped: got %h want 0000", xa_data_rd); end
    wa_ready = 1'b1;
    repeat (15) cycle();
    write_cyc(ST_ADDR, 16'h0001);
    read_cyc(ST_ADDR);
    n_checks++; if (xa_data_rd !== 16'h0000) begin n_fail++; $display("FAIL sat_clear: got %h want 0000", xa_data_rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_drain();
    test_toggle_random();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sif_wbus_bridge.md
Name: sif_wbus_bridge

Overview:
- Parametrised xbus-slave to wbus-master bridge; next generation of the serial-interface DUT.
- Posts xbus writes into a DEPTH-entry FIFO and drains them onto wbus under a valid/ready handshake (wa_ready backpressure is new).
- Keeps a shadow register file for xbus read-back.
- Exposes a status register with FIFO level, sticky overflow flag and drop counter.

Parameters:
ADDR_W, 16, xbus/wbus address width
DATA_W, 16, xbus/wbus data width (min 16)
DEPTH, 8, posted-write FIFO entries (power of 2, 2..128)
SHADOW_N, 16, shadow registers at addresses 0..SHADOW_N-1 (power of 2, SHADOW_N-1 < STATUS_ADDR)
STATUS_ADDR, all-ones (ADDR_W bits), status/control register address

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous reset, active-high
xa_addr  in  ADDR_W  xbus address
xa_data_wr  in  DATA_W  xbus write data
xa_wr_s  in  1  xbus write strobe, one access per cycle while high
xa_rd_s  in  1  xbus read strobe
xa_data_rd  out  DATA_W  xbus read data, registered
xa_busy  out  1  FIFO full (count == DEPTH)
wa_addr  out  ADDR_W  wbus address
wa_data_wr  out  DATA_W  wbus write data
wa_wr_s  out  1  wbus valid
wa_ready  in  1  wbus ready; handshake = wa_wr_s & wa_ready at posedge

Behaviour:
- Reset (async assert, sync release): xa_data_rd=0, xa_busy=0, wa_addr=0, wa_data_wr=0, wa_wr_s=0.
- Reset also clears: FIFO (empty), shadow regs, ovf flag and drop counter; FSM goes to IDLE.
- Reset mid-transfer: a pending wa_wr_s drops immediately and its beat is lost.
- Write, addr != STATUS_ADDR: push {addr,data} when count<DEPTH, or when count==DEPTH and a pop occurs on the same edge.
- Write when full with no same-edge pop: write dropped, ovf set (sticky), drop counter +1 (7-bit, saturates at 127).
- Shadow update: addr < SHADOW_N updates shadow[addr] at the same edge, even if the push is dropped.
- Write to STATUS_ADDR: never pushed. data[0]=1 clears ovf and drop counter (W1C); data[0]=0 has no effect.
- Write to STATUS_ADDR on the same edge as an overflow drop: the clear wins.
- Read: xa_rd_s at edge N -> xa_data_rd valid after edge N and held until the next read.
  - addr < SHADOW_N: returns shadow[addr].
  - addr == STATUS_ADDR: returns {ovf, drop_cnt[6:0], count[7:0]}, zero-extended to DATA_W.
  - Any other addr: returns 0.
- Read and write to the same address on one edge: read returns the old value.
- Drain FSM, output register outside the FIFO:
  - IDLE: wa_wr_s=0. If FIFO non-empty at edge: pop head into wa_addr/wa_data_wr, go VALID.
  - VALID: wa_wr_s=1, addr/data held stable until handshake.
  - On handshake: if FIFO non-empty, pop next beat (stay VALID, back-to-back, 1 beat/cycle); else go IDLE.
- Latency: write at edge N into empty bridge -> wa_wr_s=1 after edge N+1.
- Throughput: 1 beat/cycle with wa_ready tied high.
- Ordering: wbus order equals xbus write-acceptance order; addresses and data are passed unmodified.
- count = FIFO entries only; excludes the beat held in the output register.
- xa_busy is registered from count; wa_ready has no combinational path to xa_busy.

Test Plan:
- Reset, wa_ready=1; write 0x0003<-0xBEEF -> wa_wr_s high exactly one cycle, 2 edges later, wa_addr=0x0003, wa_data_wr=0xBEEF; then read 0x0003 -> xa_data_rd=0xBEEF.
- wa_ready=0; 10 writes of data 0..9 with DEPTH=8 -> beat 0 held in output register, 1..8 in FIFO, 9 dropped; xa_busy=1; status read=0x8108 (ovf=1, drop=1, count=8).
- Release wa_ready after the previous scenario -> 9 wbus beats, data 0..8 in order on consecutive cycles; status then 0x8100; write STATUS_ADDR<-0x0001 -> status 0x0000.
- wa_ready toggling 1/0 every cycle with continuous writes -> wa_addr/wa_data_wr never change while wa_wr_s=1 & wa_ready=0; no loss or duplication.
- Assert rst with wa_wr_s=1 and 4 entries queued -> wa_wr_s=0 immediately; after release status=0x0000 and shadow reads return 0.
- 140 dropped writes while full -> drop counter saturates at 127; read 0x0020 (SHADOW_N=16) -> 0.
